// File: rtl/rv32_hart_sched.sv
// Round-robin hart scheduler for the multi-hart RV32 pipeline.
// Tracks a run state per hart and offers one RUN hart per cycle to fetch,
// rotating the search start point past each accepted hart.
module rv32_hart_sched #(
  parameter int NUM_HARTS = 8,
  parameter int HART_ID_W = $clog2(NUM_HARTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_HARTS-1:0]   hart_start,
  input  logic [NUM_HARTS-1:0]   trap_clear,
  input  logic                   dec_valid,
  input  logic [HART_ID_W-1:0]   dec_hart_id,
  input  logic                   dec_trap,
  input  logic                   dec_mem,
  input  logic                   mem_done_valid,
  input  logic [HART_ID_W-1:0]   mem_done_hart_id,
  input  logic                   issue_ready,
  output logic                   issue_valid,
  output logic [HART_ID_W-1:0]   issue_hart_id,
  output logic [2*NUM_HARTS-1:0] hart_state,
  output logic                   trap_pending,
  output logic [HART_ID_W-1:0]   trap_hart_id
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10,
    TRAP = 2'b11
  } hart_state_t;

  hart_state_t          state_q [NUM_HARTS];
  hart_state_t          state_d [NUM_HARTS];
  logic [HART_ID_W-1:0] rr_ptr;
  logic [HART_ID_W-1:0] search_idx;
  logic                 found;

  // Per-hart next state: trap beats memory completion beats entering WAIT,
  // and the trap_clear/hart_start pair can only move a hart one step per cycle.
  always_comb begin
    for (int k = 0; k < NUM_HARTS; k++) begin
      state_d[k] = state_q[k];
      if (dec_valid && dec_trap && (dec_hart_id == HART_ID_W'(k)) &&
          ((state_q[k] == RUN) || (state_q[k] == WAIT))) begin
        state_d[k] = TRAP;
      end else if (mem_done_valid && (mem_done_hart_id == HART_ID_W'(k)) &&
                   (state_q[k] == WAIT)) begin
        state_d[k] = RUN;
      end else if (dec_valid && dec_mem && !dec_trap &&
                   (dec_hart_id == HART_ID_W'(k)) && (state_q[k] == RUN)) begin
        state_d[k] = WAIT;
      end else if (trap_clear[k] && (state_q[k] == TRAP)) begin
        state_d[k] = IDLE;
      end else if (hart_start[k] && (state_q[k] == IDLE)) begin
        state_d[k] = RUN;
      end
    end
  end

  // Per-hart state register; reset parks every hart in IDLE.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_HARTS; k++) begin
      if (rst) begin
        state_q[k] <= IDLE;
      end else begin
        state_q[k] <= state_d[k];
      end
    end
  end

  // Rotating search for the first RUN hart starting at rr_ptr; index 0 when none.
  always_comb begin
    found         = 1'b0;
    search_idx    = '0;
    issue_hart_id = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      search_idx = rr_ptr + HART_ID_W'(i);
      if (!found && (state_q[search_idx] == RUN)) begin
        found         = 1'b1;
        issue_hart_id = search_idx;
      end
    end
    issue_valid = found;
  end

  // Pointer moves just past an accepted hart; natural overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue_valid && issue_ready) begin
      rr_ptr <= issue_hart_id + HART_ID_W'(1);
    end
  end

  // Flatten states for observation and report the lowest-index trapped hart.
  always_comb begin
    hart_state   = '0;
    trap_pending = 1'b0;
    trap_hart_id = '0;
    for (int k = NUM_HARTS - 1; k >= 0; k--) begin
      hart_state[2*k +: 2] = state_q[k];
      if (state_q[k] == TRAP) begin
        trap_pending = 1'b1;
        trap_hart_id = HART_ID_W'(k);
      end
    end
  end

endmodule
